// File: rtl/mem_access_pkg.sv
// Shared defines for the MEM stage: aluop encodings, bus widths, FSM encoding
// and the small op-decoding helpers used by the stage and its load extender.
package mem_access_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [ALU_OP_W-1:0] EXE_OP_ADD = 8'h10;
  localparam logic [ALU_OP_W-1:0] EXE_OP_LB  = 8'h20;
  localparam logic [ALU_OP_W-1:0] EXE_OP_LH  = 8'h21;
  localparam logic [ALU_OP_W-1:0] EXE_OP_LW  = 8'h23;
  localparam logic [ALU_OP_W-1:0] EXE_OP_LBU = 8'h24;
  localparam logic [ALU_OP_W-1:0] EXE_OP_LHU = 8'h25;
  localparam logic [ALU_OP_W-1:0] EXE_OP_SB  = 8'h28;
  localparam logic [ALU_OP_W-1:0] EXE_OP_SH  = 8'h29;
  localparam logic [ALU_OP_W-1:0] EXE_OP_SW  = 8'h2B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
    return op inside {EXE_OP_LB, EXE_OP_LH, EXE_OP_LW, EXE_OP_LBU, EXE_OP_LHU};
  endfunction

  function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
    return op inside {EXE_OP_SB, EXE_OP_SH, EXE_OP_SW};
  endfunction

  // Number of byte transfers the op needs on the 8-bit RAM port.
  function automatic logic [2:0] op_bytes(input logic [ALU_OP_W-1:0] op);
    logic [2:0] n;
    n = 3'd4;
    if (op inside {EXE_OP_LB, EXE_OP_LBU, EXE_OP_SB}) n = 3'd1;
    if (op inside {EXE_OP_LH, EXE_OP_LHU, EXE_OP_SH}) n = 3'd2;
    return n;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// EX-to-MEM request, MEM-to-WB result and byte-wide RAM port bundled together.
// master is the environment side (EX stage + RAM), slave is the MEM stage.
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int AOP_W  = 8
);

  logic              valid_i;
  logic [AOP_W-1:0]  aluop_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] wData_i;
  logic [4:0]        wAddr_i;
  logic              wreg_i;

  logic [4:0]        wAddr_o;
  logic [DATA_W-1:0] wData_o;
  logic              wreg_o;
  logic              stall_o;

  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0]        ram_dout_o;
  logic              ram_wr_o;
  logic [7:0]        ram_din_i;

  modport master (
    output valid_i, aluop_i, mem_addr_i, wData_i, wAddr_i, wreg_i, ram_din_i,
    input  wAddr_o, wData_o, wreg_o, stall_o, ram_addr_o, ram_dout_o, ram_wr_o
  );

  modport slave (
    input  valid_i, aluop_i, mem_addr_i, wData_i, wAddr_i, wreg_i, ram_din_i,
    output wAddr_o, wData_o, wreg_o, stall_o, ram_addr_o, ram_dout_o, ram_wr_o
  );

endinterface

// File: rtl/mem_access_load_extend.sv
// Load result shaping: picks byte/halfword/word out of the assembled little-endian
// bytes and applies sign or zero extension according to the load op.
module mem_access_load_extend
  import mem_access_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int AOP_W  = ALU_OP_W
) (
  input  logic [AOP_W-1:0]  op,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] word
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0] bs;
    bs = b;
    if (sgn) return DATA_W'(bs);
    return DATA_W'(b);
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    hs = h;
    if (sgn) return DATA_W'(hs);
    return DATA_W'(h);
  endfunction

  always_comb begin
    word = raw;
    case (op)
      EXE_OP_LB:  word = ext_byte(raw[7:0], 1'b1);
      EXE_OP_LBU: word = ext_byte(raw[7:0], 1'b0);
      EXE_OP_LH:  word = ext_half(raw[15:0], 1'b1);
      EXE_OP_LHU: word = ext_half(raw[15:0], 1'b0);
      default:    word = raw;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the RV32I core: byte-serial little-endian loads/stores over a single
// 8-bit synchronous RAM port, one-cycle registered passthrough for everything else.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = REG_W,
  parameter int AOP_W  = ALU_OP_W
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);

  state_t state, state_nx;

  logic              accept;
  logic              acc_load;
  logic              acc_store;
  logic [1:0]        k;
  logic [1:0]        last_k;
  logic              last;

  logic [AOP_W-1:0]  op_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [4:0]        waddr_p0;
  logic              wreg_p0;
  logic [2:0]        nbytes_p0;
  logic [DATA_W-1:0] asm_p1;

  logic [DATA_W-1:0] raw_word;
  logic [DATA_W-1:0] ext_word;

  logic [DATA_W-1:0] wdata_p1;
  logic [4:0]        waddr_p1;
  logic              wreg_p1;

  logic              stall;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_wr;

  assign accept    = (state == IDLE) && bus.valid_i;
  assign acc_load  = accept && is_load(bus.aluop_i);
  assign acc_store = accept && is_store(bus.aluop_i);
  assign last_k    = 2'(nbytes_p0 - 3'd1);
  assign last      = (k == last_k);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Write strobe is gated by rst so an aborted store cannot land one more byte.
  always_comb begin
    state_nx = state;
    stall    = NOSTOP;
    ram_addr = '0;
    ram_dout = 8'h00;
    ram_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (acc_load || acc_store) begin
          stall    = STOP;
          state_nx = acc_load ? READ : WRITE;
        end
      end
      READ: begin
        stall    = STOP;
        ram_addr = addr_p0 + ADDR_W'(k);
        if (last) state_nx = DONE;
      end
      WRITE: begin
        stall    = STOP;
        ram_wr   = ~rst;
        ram_addr = addr_p0 + ADDR_W'(k);
        ram_dout = data_p0[8*k +: 8];
        if (last) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k <= 2'd0;
    end else if (state == READ || state == WRITE) begin
      k <= last ? 2'd0 : k + 2'd1;
    end else begin
      k <= 2'd0;
    end
  end

  // ---- stage p0: request captured at accept, held for the whole transaction
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0     <= bus.aluop_i;
      addr_p0   <= bus.mem_addr_i;
      data_p0   <= bus.wData_i;
      waddr_p0  <= bus.wAddr_i;
      wreg_p0   <= bus.wreg_i;
      nbytes_p0 <= op_bytes(bus.aluop_i);
    end
  end

  // ---- stage p1: read bytes arrive one cycle behind their address
  always_ff @(posedge clk) begin
    if (state == READ && k != 2'd0) asm_p1[8*(k - 2'd1) +: 8] <= bus.ram_din_i;
  end

  // The last byte is still on ram_din in DONE; splice it in rather than storing it.
  always_comb begin
    raw_word = asm_p1;
    raw_word[8*last_k +: 8] = bus.ram_din_i;
  end

  mem_access_load_extend #(
    .DATA_W (DATA_W),
    .AOP_W  (AOP_W)
  ) u_load_extend (
    .op   (op_p0),
    .raw  (raw_word),
    .word (ext_word)
  );

  // ---- stage p2: write-back register, wreg is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_p1 <= ZERO_WORD[DATA_W-1:0];
      waddr_p1 <= 5'd0;
      wreg_p1  <= 1'b0;
    end else begin
      wreg_p1 <= 1'b0;
      if (accept && !acc_load && !acc_store) begin
        wdata_p1 <= bus.wData_i;
        waddr_p1 <= bus.wAddr_i;
        wreg_p1  <= bus.wreg_i && (bus.wAddr_i != 5'd0);
      end else if (state == DONE && is_load(op_p0)) begin
        wdata_p1 <= ext_word;
        waddr_p1 <= waddr_p0;
        wreg_p1  <= wreg_p0 && (waddr_p0 != 5'd0);
      end
    end
  end

  assign bus.wData_o    = wdata_p1;
  assign bus.wAddr_o    = waddr_p1;
  assign bus.wreg_o     = wreg_p1;
  assign bus.stall_o    = stall;
  assign bus.ram_addr_o = ram_addr;
  assign bus.ram_dout_o = ram_dout;
  assign bus.ram_wr_o   = ram_wr;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the five-stage RV32I core; the downstream consumer of the execute stage's aluop, memory address, store/result data and write-back tags.
- Loads and stores go over the single 8-bit synchronous RAM port, byte-serial and little-endian. Load results are assembled with sign or zero extension.
- Non-memory results pass through to write-back with one registered cycle.
- Drives the pipeline stall while a memory transaction is in flight.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, register/data width
- AOP_W, 8, aluop width; must match the shared AluOpBus

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX result valid this cycle
- aluop_i  in  AOP_W  operation from EX
- mem_addr_i  in  ADDR_W  effective address (loads/stores)
- wData_i  in  DATA_W  store value (stores) or ALU result (others)
- wAddr_i  in  5  destination register
- wreg_i  in  1  write-back enable
- wAddr_o  out  5  destination to WB
- wData_o  out  DATA_W  write-back data
- wreg_o  out  1  write-back enable (single-cycle pulse per instruction)
- stall_o  out  1  hold upstream stages
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_dout_o  out  8  RAM write byte
- ram_wr_o  out  1  RAM write strobe
- ram_din_i  in  8  RAM read byte; valid one cycle after its address

Behaviour:
- Reset: FSM to IDLE.
  - All outputs 0: wAddr_o, wData_o, wreg_o, stall_o, ram_addr_o, ram_dout_o, ram_wr_o.
  - A reset mid-transaction aborts it. No further writes, no write-back.
- States: IDLE, READ, WRITE, DONE.
- Byte count N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
- Byte counter k counts 0..N-1.
- Address generation: ram_addr_o = addr + k, modulo 2^32 (wrap permitted). Unaligned accesses are legal.
- Accept: in IDLE with valid_i=1.
  - stall_o asserts combinationally in the accept cycle for memory ops.
  - The block latches op, addr, data, wAddr and wreg.
- Non-memory op:
  - Next cycle: wData_o=wData_i, wAddr_o=wAddr_i, wreg_o=wreg_i. Stays in IDLE.
  - No stall.
- Load:
  - IDLE→READ.
  - Cycles 1..N after accept: drive ram_addr_o=addr+k.
  - ram_din_i sampled the following cycle into byte k of the assembly register.
  - After the last byte is sampled (cycle N+1), go to DONE.
  - Cycle N+2: wData_o registered, wreg_o=wreg, back to IDLE.
  - Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Store:
  - IDLE→WRITE.
  - Cycles 1..N: ram_wr_o=1, ram_addr_o=addr+k, ram_dout_o=data[8k+7:8k].
  - Then DONE for one cycle with wreg_o=0, back to IDLE.
- Stall window: stall_o is high from the accept cycle through the last cycle before the DONE cycle. It is low in the DONE cycle so upstream advances exactly once.
- Upstream contract: EX holds its inputs while stall_o=1. The block ignores its inputs outside IDLE.
- ram_wr_o is only ever high in WRITE. ram_addr_o is 0 in IDLE and DONE.
- wreg_o: asserted only in the write-back cycle; forced 0 when wAddr is 0.
- Back-to-back: a new valid_i may be accepted in the cycle after DONE (IDLE).

Decomposition:
- Shared defines package holds:
  - EXE_OP_LB/LH/LW/LBU/LHU/SB/SH/SW encodings, AluOpBus, RegBus, RegAddrBus widths
  - ZeroWord
  - the FSM state encoding and the STOP/NOSTOP constants
- One natural sub-module, load_extend: combinational byte/halfword/word selection plus sign/zero extension. The FSM, counter and RAM drive stay in mem_access.

Test Plan:
- ADD passthrough: wData_i=0x0000002A, wAddr_i=5, wreg_i=1 → next cycle wData_o=0x2A, wAddr_o=5, wreg_o=1; stall_o never high.
- LW at 0x100, RAM holds 78 56 34 12:
  - ram_addr_o=0x100..0x103 on cycles 1-4
  - wData_o=0x12345678, wreg_o=1 at cycle 6
  - stall_o high cycles 0-4
- LB vs LBU at 0x200 holding 0x80: LB → wData_o=0xFFFFFF80; LBU → 0x00000080.
- SH with wData_i=0xDEADBEEF at 0x300:
  - ram_wr_o=1 for exactly 2 cycles: 0x300←0xEF, 0x301←0xBE
  - wreg_o=0; RAM 0x302/0x303 untouched
- LH at 0xFFFFFFFF holding 0x34 and 0x12 at 0x00000000 → addresses 0xFFFFFFFF then 0x00000000, wData_o=0x00001234.
- SW at 0x400, rst asserted in cycle 2 → only 0x400 written; no writes afterward; all outputs 0 the cycle after rst; next ADD processes normally.
